// File: rtl/dma_buffer_bus_writer_if.sv
// ----------------------------------------------------------------------------
// dma_buffer_bus_writer_if
// Signal bundle for the shared system bus as seen by a burst-write master.
//   master modport : the bus writer. It drives request/begin/address-data/
//                    burst size/direction/byte enables/data valid/end, and
//                    receives grant/busy/error.
//   slave modport  : the arbiter plus memory slave side, which mirrors the
//                    master modport.
// Signal names keep their Out/In suffixes from the writer's point of view.
// ----------------------------------------------------------------------------
interface dma_buffer_bus_writer_if;
  logic        requestOut;
  logic        grantedIn;
  logic        beginTransactionOut;
  logic [31:0] addressDataOut;
  logic [7:0]  burstSizeOut;
  logic        readNotWriteOut;
  logic [3:0]  byteEnablesOut;
  logic        dataValidOut;
  logic        busyIn;
  logic        errorIn;
  logic        endTransactionOut;

  modport master (
    output requestOut, beginTransactionOut, addressDataOut, burstSizeOut,
           readNotWriteOut, byteEnablesOut, dataValidOut, endTransactionOut,
    input  grantedIn, busyIn, errorIn
  );

  modport slave (
    input  requestOut, beginTransactionOut, addressDataOut, burstSizeOut,
           readNotWriteOut, byteEnablesOut, dataValidOut, endTransactionOut,
    output grantedIn, busyIn, errorIn
  );
endinterface

// File: rtl/dma_buffer_bus_writer.sv
// ----------------------------------------------------------------------------
// dma_buffer_bus_writer
// Drain side of the DMA dual-port buffer. It reads consecutive buffer words
// and writes them to system memory as burst write transactions. A block is
// split into bursts of at most burstSizeIn+1 beats, and the bus is arbitrated
// once per burst.
// Ports:
//   clock, reset          : single rising-edge clock, synchronous active-high reset
//   startIn               : one-cycle start pulse, accepted only when idle
//   bufferStartIn         : first buffer word of the block
//   busStartAddressIn     : first bus byte address (word aligned)
//   blockSizeIn           : words to transfer (0 completes immediately)
//   burstSizeIn           : maximum beats per burst minus one
//   bufferAddressOut      : buffer read address
//   bufferDataIn          : buffer read data, same-cycle as the address
//   bus                   : shared-bus master port (see dma_buffer_bus_writer_if)
//   busyOut/doneOut/errorOut : status to the DMA control registers
// ----------------------------------------------------------------------------
module dma_buffer_bus_writer #(
  parameter int bitwidth    = 32,
  parameter int bufferDepth = 512,
  localparam int AW         = $clog2(bufferDepth)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 startIn,
  input  logic [AW-1:0]        bufferStartIn,
  input  logic [31:0]          busStartAddressIn,
  input  logic [9:0]           blockSizeIn,
  input  logic [7:0]           burstSizeIn,
  output logic [AW-1:0]        bufferAddressOut,
  input  logic [bitwidth-1:0]  bufferDataIn,
  dma_buffer_bus_writer_if.master bus,
  output logic                 busyOut,
  output logic                 doneOut,
  output logic                 errorOut
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQUEST = 3'd1,
    ST_INIT    = 3'd2,
    ST_DATA    = 3'd3,
    ST_END     = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [9:0]    remaining_q, remaining_d;
  logic [8:0]    beats_q, beats_d;       // beats still to send in this burst
  logic          req_q, req_d;
  logic          begin_q, begin_d;
  logic [31:0]   addr_q, addr_d;         // address shown during the begin cycle
  logic [7:0]    burst_q, burst_d;
  logic [3:0]    be_q, be_d;
  logic          valid_q, valid_d;
  logic          end_q, end_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic [8:0]    burst_beats_s;
  logic [8:0]    beats_calc_s;
  logic [AW-1:0] ptr_inc_s;

  // Size of the next burst: the configured maximum, trimmed to what is left.
  assign burst_beats_s = {1'b0, burstSizeIn} + 9'd1;
  assign beats_calc_s  = ({1'b0, burst_beats_s} < remaining_q) ? burst_beats_s : remaining_q[8:0];
  // Buffer pointer advance with explicit wrap, so non-power-of-two depths also work.
  assign ptr_inc_s     = (ptr_q == AW'(bufferDepth - 1)) ? {AW{1'b0}} : ptr_q + AW'(1);

  // Next-state and next-output computation for the burst sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    bus_addr_d  = bus_addr_q;
    remaining_d = remaining_q;
    beats_d     = beats_q;
    req_d       = 1'b0;
    begin_d     = 1'b0;
    addr_d      = 32'd0;
    burst_d     = 8'd0;
    be_d        = 4'd0;
    valid_d     = 1'b0;
    end_d       = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE already reports busyOut=0, so it accepts a start like IDLE does.
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (startIn) begin
          ptr_d       = bufferStartIn;
          bus_addr_d  = busStartAddressIn;
          remaining_d = blockSizeIn;
          error_d     = 1'b0;
          if (blockSizeIn == 10'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_REQUEST;
            req_d   = 1'b1;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQUEST: begin
        req_d = 1'b1;
        if (bus.grantedIn) begin
          state_d = ST_INIT;
          beats_d = beats_calc_s;
          begin_d = 1'b1;
          addr_d  = bus_addr_q;
          burst_d = 8'(beats_calc_s - 9'd1);
          be_d    = 4'hF;
        end else begin
          state_d = ST_REQUEST;
        end
      end

      ST_INIT: begin
        if (bus.errorIn) begin
          // Abort: bus released immediately, no end strobe, report via done+error.
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          state_d = ST_DATA;
          req_d   = 1'b1;
          valid_d = 1'b1;
        end
      end

      ST_DATA: begin
        if (bus.errorIn) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else if (!bus.busyIn) begin
          ptr_d       = ptr_inc_s;
          bus_addr_d  = bus_addr_q + 32'd4;
          remaining_d = remaining_q - 10'd1;
          beats_d     = beats_q - 9'd1;
          if (beats_q == 9'd1) begin
            state_d = ST_END;
            end_d   = 1'b1;
          end else begin
            req_d   = 1'b1;
            valid_d = 1'b1;
          end
        end else begin
          // Slave stall: pointer and beat held, so address and data stay put.
          req_d   = 1'b1;
          valid_d = 1'b1;
        end
      end

      ST_END: begin
        if (remaining_q != 10'd0) begin
          state_d = ST_REQUEST;
          req_d   = 1'b1;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset returns to IDLE with every output low.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= {AW{1'b0}};
      bus_addr_q  <= 32'd0;
      remaining_q <= 10'd0;
      beats_q     <= 9'd0;
      req_q       <= 1'b0;
      begin_q     <= 1'b0;
      addr_q      <= 32'd0;
      burst_q     <= 8'd0;
      be_q        <= 4'd0;
      valid_q     <= 1'b0;
      end_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      bus_addr_q  <= bus_addr_d;
      remaining_q <= remaining_d;
      beats_q     <= beats_d;
      req_q       <= req_d;
      begin_q     <= begin_d;
      addr_q      <= addr_d;
      burst_q     <= burst_d;
      be_q        <= be_d;
      valid_q     <= valid_d;
      end_q       <= end_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  // The buffer answers within the cycle, so data beats flow straight from
  // bufferDataIn; every other cycle shows the registered address (or zero).
  assign bus.addressDataOut      = valid_q ? 32'(bufferDataIn) : addr_q;
  assign bus.requestOut          = req_q;
  assign bus.beginTransactionOut = begin_q;
  assign bus.burstSizeOut        = burst_q;
  assign bus.readNotWriteOut     = 1'b0;
  assign bus.byteEnablesOut      = be_q;
  assign bus.dataValidOut        = valid_q;
  assign bus.endTransactionOut   = end_q;
  assign bufferAddressOut        = ptr_q;
  assign busyOut                 = busy_q;
  assign doneOut                 = done_q;
  assign errorOut                = error_q;

endmodule

// File: tb/tb_dma_buffer_bus_writer.sv
// ----------------------------------------------------------------------------
// tb_dma_buffer_bus_writer
// Self-checking bench for dma_buffer_bus_writer. A table of transfers plus
// random transfers are run against a reference model that plans the bursts
// from the block/burst sizes with plain arithmetic. A few hand-written
// sequences cover reset behaviour.
// ----------------------------------------------------------------------------
module tb_dma_buffer_bus_writer;
  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  buf_start;
  logic [31:0] bus_start;
  logic [9:0]  blk_size;
  logic [7:0]  burst_size;
  logic [8:0]  buf_addr;
  logic [31:0] buf_data;
  logic        busy, done, err;
  logic [31:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  dma_buffer_bus_writer_if bus_if();

  dma_buffer_bus_writer #(.bitwidth(32), .bufferDepth(DEPTH)) dut (
    .clock(clk), .reset(rst), .startIn(start), .bufferStartIn(buf_start),
    .busStartAddressIn(bus_start), .blockSizeIn(blk_size), .burstSizeIn(burst_size),
    .bufferAddressOut(buf_addr), .bufferDataIn(buf_data), .bus(bus_if),
    .busyOut(busy), .doneOut(done), .errorOut(err)
  );

  always #5 clk = ~clk;
  assign buf_data = mem[buf_addr];

  typedef struct {
    int          blk;
    int          burst;
    int          bstart;
    logic [31:0] baddr;
    int          gdly;        // REQUEST cycles before grant
    int          stall_beat;  // beat index stalled, -1 none
    int          stall_len;
    int          err_beat;    // beat index with errorIn, -1 none
    bit          rnd_busy;
    int          restart_at;  // cycle to pulse a stray start, -1 none
    int          exp_bursts;  // -1: take from the model
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int blk, int burst, int bstart, logic [31:0] baddr, int gdly,
                              int sb, int sl, int eb, int rs, int nb, bit ee);
    vec_t v;
    v.blk = blk; v.burst = burst; v.bstart = bstart; v.baddr = baddr; v.gdly = gdly;
    v.stall_beat = sb; v.stall_len = sl; v.err_beat = eb; v.rnd_busy = 1'b0;
    v.restart_at = rs; v.exp_bursts = nb; v.exp_err = ee;
    return v;
  endfunction

  task automatic run_xfer(input vec_t v, input string tag);
    logic [31:0] m_addr[$];
    int          m_beats[$];
    int          m_first[$];
    logic [31:0] g_addr[$];
    logic [7:0]  g_burst[$];
    logic [31:0] g_data[$];
    logic [8:0]  g_bufa[$];
    int rem, idx, b, n_issued, n_ended, n_acc, exp_n;
    int req_rises, ends, done_cyc, last_end, req_wait, stall_left, stall_cycles, n_got;
    logic [31:0] a, hold_data;
    logic [8:0]  hold_ba;
    logic prev_req, err_pending, hold_pending, seen_done;
    bit   st;

    // Reference plan: burst i starts at beat m_first[i], holds m_beats[i] words.
    rem = v.blk; a = v.baddr; idx = 0;
    while (rem > 0) begin
      b = (v.burst + 1 < rem) ? v.burst + 1 : rem;
      m_addr.push_back(a); m_beats.push_back(b); m_first.push_back(idx);
      a = a + 32'(4 * b); idx += b; rem -= b;
    end
    n_issued = m_addr.size(); n_ended = n_issued; n_acc = v.blk;
    if (v.err_beat >= 0) begin
      n_acc = v.err_beat; n_issued = 0; n_ended = 0;
      foreach (m_first[i]) begin
        if (m_first[i] <= v.err_beat) n_issued++;
        if (m_first[i] + m_beats[i] <= v.err_beat) n_ended++;
      end
    end
    exp_n = (v.exp_bursts >= 0) ? v.exp_bursts : n_issued;

    @(negedge clk);
    start = 1'b1; buf_start = 9'(v.bstart); bus_start = v.baddr;
    blk_size = 10'(v.blk); burst_size = 8'(v.burst);
    @(negedge clk);
    start = 1'b0;

    req_rises = 0; ends = 0; done_cyc = -1; last_end = -100; req_wait = 0;
    stall_left = v.stall_len; stall_cycles = 0;
    prev_req = 1'b0; err_pending = 1'b0; hold_pending = 1'b0; seen_done = 1'b0;
    hold_data = 32'd0; hold_ba = 9'd0;

    for (int cyc = 0; cyc < 4000 && !seen_done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == v.restart_at) begin
        start = 1'b1; blk_size = 10'd0; buf_start = 9'd100; bus_start = 32'hDEAD_0000;
      end else begin
        start = 1'b0;
      end
      // ---- sample ----
      if (cyc == 0) chk({tag, "_err_clr"}, 64'(err), 64'd0);
      if (bus_if.requestOut && !prev_req) req_rises++;
      prev_req = bus_if.requestOut;
      if (hold_pending) begin
        chk({tag, "_hold"}, {buf_addr, bus_if.addressDataOut, bus_if.dataValidOut},
            {hold_ba, hold_data, 1'b1});
        hold_pending = 1'b0;
      end
      if (err_pending) begin
        chk({tag, "_err_quiet"},
            {bus_if.requestOut, bus_if.beginTransactionOut, bus_if.dataValidOut,
             bus_if.endTransactionOut, bus_if.byteEnablesOut, bus_if.addressDataOut,
             bus_if.burstSizeOut, err},
            {1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 8'd0, 1'b1});
        err_pending = 1'b0;
      end
      if (bus_if.beginTransactionOut) begin
        g_addr.push_back(bus_if.addressDataOut);
        g_burst.push_back(bus_if.burstSizeOut);
        chk({tag, "_begin_ctl"},
            {bus_if.byteEnablesOut, bus_if.readNotWriteOut, bus_if.dataValidOut, bus_if.endTransactionOut},
            {4'hF, 1'b0, 1'b0, 1'b0});
      end
      if (bus_if.endTransactionOut) begin
        ends++; last_end = cyc;
        chk({tag, "_end_quiet"},
            {bus_if.beginTransactionOut, bus_if.dataValidOut, bus_if.byteEnablesOut,
             bus_if.addressDataOut, bus_if.burstSizeOut}, 64'd0);
      end
      if (done) begin
        seen_done = 1'b1; done_cyc = cyc;
        chk({tag, "_done_status"}, {busy, err}, {1'b0, v.exp_err});
      end
      // ---- drive slave responses ----
      bus_if.grantedIn = 1'b0; bus_if.busyIn = 1'b0; bus_if.errorIn = 1'b0;
      if (bus_if.requestOut && !bus_if.beginTransactionOut && !bus_if.dataValidOut) begin
        if (req_wait >= v.gdly) bus_if.grantedIn = 1'b1;
        req_wait++;
      end else begin
        req_wait = 0;
      end
      if (bus_if.dataValidOut) begin
        n_got = g_data.size();
        st = (n_got == v.stall_beat) && (stall_left > 0);
        if (n_got == v.err_beat) begin
          bus_if.errorIn = 1'b1; err_pending = 1'b1;
        end else if (st || (v.rnd_busy && $urandom_range(0, 3) == 0)) begin
          bus_if.busyIn = 1'b1;
          if (st) stall_left--;
          stall_cycles++;
          hold_pending = 1'b1; hold_data = bus_if.addressDataOut; hold_ba = buf_addr;
        end else begin
          g_data.push_back(bus_if.addressDataOut);
          g_bufa.push_back(buf_addr);
        end
      end
    end
    start = 1'b0;

    if (!seen_done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no doneOut required doneOut within 4000 cycles", tag);
    end
    chk({tag, "_bursts"}, 64'(g_addr.size()), 64'(exp_n));
    for (int i = 0; i < g_addr.size() && i < m_addr.size(); i++) begin
      chk({tag, "_burst_addr"}, 64'(g_addr[i]), 64'(m_addr[i]));
      chk({tag, "_burst_len"}, 64'(g_burst[i]), 64'(m_beats[i] - 1));
    end
    chk({tag, "_beats"}, 64'(g_data.size()), 64'(n_acc));
    for (int i = 0; i < g_data.size() && i < n_acc; i++) begin
      chk({tag, "_beat"}, {g_bufa[i], g_data[i]},
          {9'((v.bstart + i) % DEPTH), mem[(v.bstart + i) % DEPTH]});
    end
    chk({tag, "_ends"}, 64'(ends), 64'(n_ended));
    chk({tag, "_req_phases"}, 64'(req_rises), 64'(exp_n));
    if (v.blk == 0) chk({tag, "_done_at"}, 64'(done_cyc), 64'd0);
    else if (v.err_beat < 0) chk({tag, "_done_after_end"}, 64'(done_cyc - last_end), 64'd1);
    if (!v.rnd_busy && v.stall_len > 0) chk({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(v.stall_len));
    @(negedge clk);
    chk({tag, "_idle_after"}, {busy, done, bus_if.requestOut}, 64'd0);
  endtask

  initial begin
    vec_t tbl[10];
    vec_t r;

    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
    rst = 1'b1; start = 1'b0; buf_start = 9'd0; bus_start = 32'd0;
    blk_size = 10'd0; burst_size = 8'd0;
    bus_if.grantedIn = 1'b0; bus_if.busyIn = 1'b0; bus_if.errorIn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state",
        {busy, done, err, buf_addr, bus_if.requestOut, bus_if.beginTransactionOut,
         bus_if.dataValidOut, bus_if.endTransactionOut, bus_if.byteEnablesOut,
         bus_if.readNotWriteOut, bus_if.burstSizeOut, bus_if.addressDataOut}, 64'd0);
    rst = 1'b0;

    //              blk burst bstart baddr          gdly sb  sl eb  rs  nb ee
    tbl[0] = mk(  4,   7,    0, 32'h0000_1000, 0, -1, 0, -1, -1, 1, 1'b0); // single burst
    tbl[1] = mk( 10,   3,    0, 32'h0000_1000, 0, -1, 0, -1, -1, 3, 1'b0); // 4+4+2
    tbl[2] = mk(  4,   7,   20, 32'h0000_3000, 1,  2, 3, -1, -1, 1, 1'b0); // stall beat 2
    tbl[3] = mk(  4,   7,  510, 32'h0000_4000, 0, -1, 0, -1, -1, 1, 1'b0); // buffer wrap
    tbl[4] = mk(  4,   7,    0, 32'h0000_5000, 0, -1, 0,  1, -1, 1, 1'b1); // error beat 1
    tbl[5] = mk(  5,   1,   40, 32'h0000_6000, 2, -1, 0, -1, -1, 3, 1'b0); // clears error
    tbl[6] = mk(  0,   3,    0, 32'h0000_7000, 0, -1, 0, -1, -1, 0, 1'b0); // empty block
    tbl[7] = mk(  4,   1,  100, 32'hFFFF_FFF8, 0, -1, 0, -1, -1, 2, 1'b0); // bus addr wrap
    tbl[8] = mk(  6,   2,  200, 32'h0000_8000, 1, -1, 0, -1,  3, 2, 1'b0); // start while busy
    tbl[9] = mk(300, 255,  300, 32'h0000_9000, 0, -1, 0, -1, -1, 2, 1'b0); // 256+44
    for (int i = 0; i < 10; i++) run_xfer(tbl[i], $sformatf("vec%0d", i));

    for (int t = 0; t < 25; t++) begin
      r.blk        = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
      r.burst      = ($urandom_range(0, 5) == 0) ? 255 : int'($urandom_range(0, 9));
      r.bstart     = int'($urandom_range(0, DEPTH - 1));
      r.baddr      = $urandom() & 32'hFFFF_FFFC;
      r.gdly       = int'($urandom_range(0, 3));
      r.stall_beat = -1; r.stall_len = 0;
      r.err_beat   = (r.blk > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, r.blk - 1)) : -1;
      r.rnd_busy   = 1'b1; r.restart_at = -1; r.exp_bursts = -1;
      r.exp_err    = (r.err_beat >= 0);
      run_xfer(r, $sformatf("rnd%0d", t));
    end

    // Reset in the middle of DATA: everything low on the next cycle.
    @(negedge clk);
    start = 1'b1; buf_start = 9'd0; bus_start = 32'h0000_2000; blk_size = 10'd8; burst_size = 8'd7;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !bus_if.dataValidOut; i++) begin
      bus_if.grantedIn = bus_if.requestOut;
      @(negedge clk);
    end
    bus_if.grantedIn = 1'b0;
    chk("rst_reach_data", 64'(bus_if.dataValidOut), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs",
        {busy, done, err, buf_addr, bus_if.requestOut, bus_if.beginTransactionOut,
         bus_if.dataValidOut, bus_if.endTransactionOut, bus_if.byteEnablesOut,
         bus_if.burstSizeOut, bus_if.addressDataOut}, 64'd0);

    // Start coincident with reset is ignored.
    start = 1'b1; blk_size = 10'd4;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_ignored", {busy, done, bus_if.requestOut}, 64'd0);
    @(negedge clk);
    chk("rst_start_idle", {busy, done, bus_if.requestOut}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
